// File: rtl/lcd_bus_reader.sv
// lcd_bus_reader: HD44780-style read cycles (RW=1) on the shared LCD bus.
// Performs a single IR/DR read or a busy-flag poll. The bus is never driven.
module lcd_bus_reader #(
    parameter logic [31:0] SETUP_WAIT    = 32'd2,
    parameter logic [31:0] ENABLE_WAIT   = 32'd12,
    parameter logic [31:0] RECOVERY_WAIT = 32'd14,
    parameter logic [31:0] POLL_LIMIT    = 32'd100000
) (
    input  logic       CLOCK_50MHZ,
    input  logic       BUTTON_SOUTH,
    input  logic       READ_REQ,
    input  logic       READ_SEL,
    input  logic       POLL_MODE,
    output logic       READY,
    output logic       READ_DONE,
    output logic [7:0] READ_DATA,
    output logic       BUSY_TIMEOUT,
    input  logic [7:0] LCD_DATA_IN,
    output logic       LCD_DATA_OE,
    output logic       LCD_ENABLE,
    output logic       LCD_REGISTER_SELECT,
    output logic       LCD_READ_WRITE
);

    typedef enum logic [2:0] {IDLE, SETUP, E_HIGH, RECOVER, DONE} state_t;

    state_t      state, state_nx;
    logic [31:0] cnt, cnt_nx;
    logic [31:0] poll_cnt, poll_cnt_nx;
    logic        mode_q, mode_nx;
    logic        sel_q, sel_nx;
    logic        tmo_nx;
    logic        sample;
    logic        rw_nx;

    assign LCD_DATA_OE = 1'b0;
    // Pins are always decoded from the next state so every output is a flop.
    assign rw_nx = (state_nx == SETUP) || (state_nx == E_HIGH) || (state_nx == RECOVER);

    // Next-state, cycle counter, poll count and capture logic.
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt + 32'd1;
        poll_cnt_nx = poll_cnt;
        mode_nx     = mode_q;
        sel_nx      = sel_q;
        tmo_nx      = BUSY_TIMEOUT;
        sample      = 1'b0;
        case (state)
            IDLE: begin
                cnt_nx = 32'd0;
                if (READ_REQ) begin
                    state_nx    = SETUP;
                    mode_nx     = POLL_MODE;
                    sel_nx      = READ_SEL;
                    tmo_nx      = 1'b0;
                    poll_cnt_nx = 32'd0;
                end
            end
            SETUP: begin
                if (cnt + 32'd1 >= SETUP_WAIT) begin
                    state_nx = E_HIGH;
                    cnt_nx   = 32'd0;
                end
            end
            E_HIGH: begin
                if (cnt + 32'd1 >= ENABLE_WAIT) begin
                    state_nx = RECOVER;
                    cnt_nx   = 32'd0;
                    sample   = 1'b1;
                end
            end
            RECOVER: begin
                if (cnt + 32'd1 >= RECOVERY_WAIT) begin
                    cnt_nx = 32'd0;
                    if (!mode_q || !READ_DATA[7]) begin
                        state_nx = DONE;
                    end else if ((POLL_LIMIT != 32'd0) &&
                                 ({1'b0, poll_cnt} + 33'd1 == {1'b0, POLL_LIMIT})) begin
                        state_nx = DONE;
                        tmo_nx   = 1'b1;
                    end else begin
                        state_nx = SETUP;
                        // Only reachable at the maximum with POLL_LIMIT=0: saturate.
                        if (poll_cnt != 32'hFFFF_FFFF) poll_cnt_nx = poll_cnt + 32'd1;
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
                cnt_nx   = 32'd0;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = 32'd0;
            end
        endcase
    end

    // State, counters, captured request and registered pin outputs.
    always_ff @(posedge CLOCK_50MHZ or posedge BUTTON_SOUTH) begin
        if (BUTTON_SOUTH) begin
            state               <= IDLE;
            cnt                 <= 32'd0;
            poll_cnt            <= 32'd0;
            mode_q              <= 1'b0;
            sel_q               <= 1'b0;
            BUSY_TIMEOUT        <= 1'b0;
            READ_DATA           <= 8'h00;
            READY               <= 1'b1;
            READ_DONE           <= 1'b0;
            LCD_ENABLE          <= 1'b0;
            LCD_READ_WRITE      <= 1'b0;
            LCD_REGISTER_SELECT <= 1'b0;
        end else begin
            state               <= state_nx;
            cnt                 <= cnt_nx;
            poll_cnt            <= poll_cnt_nx;
            mode_q              <= mode_nx;
            sel_q               <= sel_nx;
            BUSY_TIMEOUT        <= tmo_nx;
            if (sample) READ_DATA <= LCD_DATA_IN;
            READY               <= (state_nx == IDLE);
            READ_DONE           <= (state_nx == DONE);
            LCD_ENABLE          <= (state_nx == E_HIGH);
            LCD_READ_WRITE      <= rw_nx;
            LCD_REGISTER_SELECT <= rw_nx && !mode_nx && sel_nx;
        end
    end

endmodule

// File: tb/tb_lcd_bus_reader.sv
// Scoreboard bench for lcd_bus_reader: two instances (default limit and
// POLL_LIMIT=4) see identical stimulus; a reference model predicts each
// completion and per-instance monitors check READ_DONE against it.
module tb_lcd_bus_reader;

    localparam int PER = 2 + 12 + 14;

    logic       clk = 1'b0;
    logic       rst, req, sel, poll;
    logic [7:0] db;
    logic       ready_a, done_a, tmo_a, oe_a, e_a, rs_a, rw_a;
    logic       ready_b, done_b, tmo_b, oe_b, e_b, rs_b, rw_b;
    logic [7:0] data_a, data_b;

    always #10 clk = ~clk;

    lcd_bus_reader dut_a (
        .CLOCK_50MHZ(clk), .BUTTON_SOUTH(rst), .READ_REQ(req), .READ_SEL(sel),
        .POLL_MODE(poll), .READY(ready_a), .READ_DONE(done_a), .READ_DATA(data_a),
        .BUSY_TIMEOUT(tmo_a), .LCD_DATA_IN(db), .LCD_DATA_OE(oe_a),
        .LCD_ENABLE(e_a), .LCD_REGISTER_SELECT(rs_a), .LCD_READ_WRITE(rw_a));

    lcd_bus_reader #(.POLL_LIMIT(32'd4)) dut_b (
        .CLOCK_50MHZ(clk), .BUTTON_SOUTH(rst), .READ_REQ(req), .READ_SEL(sel),
        .POLL_MODE(poll), .READY(ready_b), .READ_DONE(done_b), .READ_DATA(data_b),
        .BUSY_TIMEOUT(tmo_b), .LCD_DATA_IN(db), .LCD_DATA_OE(oe_b),
        .LCD_ENABLE(e_b), .LCD_REGISTER_SELECT(rs_b), .LCD_READ_WRITE(rw_b));

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic       tmo;
    } exp_t;

    exp_t       qa[$], qb[$];
    int         n_cmp = 0, n_bad = 0;
    int         cyc = 0;
    logic [7:0] seq [8];
    int         pidx = 0;
    logic       exp_rs = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference: n-th read returns seq[n]; poll stops on a clear busy bit or the limit.
    function automatic exp_t model(input int c, input bit pm, input int limit);
        exp_t       r;
        int         reads;
        logic [7:0] v;
        reads  = 1;
        r.tmo  = 1'b0;
        r.data = seq[0];
        if (pm) begin
            for (int i = 0; i < 64; i++) begin
                v      = seq[(i > 7) ? 7 : i];
                r.data = v;
                reads  = i + 1;
                if (!v[7]) break;
                if (limit != 0 && i + 1 == limit) begin
                    r.tmo = 1'b1;
                    break;
                end
            end
        end
        r.cyc = c + reads * PER + 1;
        return r;
    endfunction

    // LCD model: presents seq[n] during the n-th read of the current transaction.
    logic e_pd = 1'b0;
    always @(negedge clk) begin
        if (ready_a) pidx = 0;
        else if (e_pd && !e_a && pidx < 7) pidx = pidx + 1;
        e_pd = e_a;
        db   = seq[pidx];
    end

    // Completion monitors.
    always @(negedge clk) begin
        exp_t x;
        if (!rst) begin
            if (done_a) begin
                if (qa.size() == 0) fail_now("a_unexpected_done");
                else begin
                    x = qa.pop_front();
                    chk("a_done_cycle", cyc, x.cyc);
                    chk("a_read_data", data_a, x.data);
                    chk("a_timeout", tmo_a, x.tmo);
                    chk("a_oe", oe_a, 0);
                end
            end
            if (done_b) begin
                if (qb.size() == 0) fail_now("b_unexpected_done");
                else begin
                    x = qb.pop_front();
                    chk("b_done_cycle", cyc, x.cyc);
                    chk("b_read_data", data_b, x.data);
                    chk("b_timeout", tmo_b, x.tmo);
                    chk("b_oe", oe_b, 0);
                end
            end
        end
    end

    // Bus timing monitor on instance a: E width, E gap, RS/RW while E is high.
    logic pe = 1'b0, gap_ok = 1'b0;
    int   wid = 0, gap = 0;
    always @(negedge clk) begin
        if (rst) begin
            gap_ok = 1'b0;
        end else if (e_a && !pe) begin
            if (gap_ok) chk("e_low_gap", gap, 16);
            chk("rw_at_e_rise", rw_a, 1);
            chk("rs_at_e_rise", rs_a, exp_rs);
            wid = 1;
        end else if (e_a) begin
            wid++;
            chk("rs_rw_during_e", {rw_a, rs_a}, {1'b1, exp_rs});
        end else if (pe) begin
            chk("e_width", wid, 12);
            gap    = 1;
            gap_ok = 1'b1;
        end else begin
            gap++;
            if (ready_a) gap_ok = 1'b0;
        end
        pe = e_a;
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!(ready_a && ready_b) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) fail_now("idle_wait_expired");
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        chk("idle_pins", {e_a, rw_a, rs_a, e_b, rw_b, rs_b}, 6'b0);
    endtask

    // Drive one request for a cycle; caller has waited for IDLE.
    task automatic issue(input bit s, input bit pm);
        int c;
        c      = cyc;
        qa.push_back(model(c, pm, 100000));
        qb.push_back(model(c, pm, 4));
        exp_rs = pm ? 1'b0 : s;
        sel    = s;
        poll   = pm;
        req    = 1'b1;
        @(negedge clk);
        req    = 1'b0;
        chk("ready_drop", {ready_a, ready_b}, 2'b00);
        chk("rw_from_k1", rw_a, 1);
        chk("rs_from_k1", rs_a, exp_rs);
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_e_rw_rs"}, {e_a, rw_a, rs_a, e_b, rw_b, rs_b}, 6'b0);
        chk({tag, "_ready"}, {ready_a, ready_b}, 2'b11);
        chk({tag, "_done_tmo"}, {done_a, tmo_a, done_b, tmo_b}, 4'b0);
        chk({tag, "_data"}, {data_a, data_b}, 16'h0);
    endtask

    // Asynchronous reset pulse placed away from any clock edge.
    task automatic mid_reset(input string tag);
        #3 rst = 1'b1;
        #1 reset_check(tag);
        qa.delete();
        qb.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_e();
        int n;
        n = 0;
        while (!e_a && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail_now("e_wait_expired");
    endtask

    initial begin
        #5ms;
        $display("FAIL global_time_limit");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1; req = 1'b0; sel = 1'b0; poll = 1'b0;
        for (int i = 0; i < 8; i++) seq[i] = 8'h00;
        repeat (3) @(negedge clk);
        reset_check("por");
        rst = 1'b0;
        wait_idle();

        // Single data read of 0x41.
        for (int i = 0; i < 8; i++) seq[i] = 8'h41;
        issue(1'b1, 1'b0);
        wait_idle();

        // Poll: busy for three reads, then ready.
        seq[0] = 8'h85; seq[1] = 8'h85; seq[2] = 8'h85;
        for (int i = 3; i < 8; i++) seq[i] = 8'h05;
        issue(1'b1, 1'b1);
        wait_idle();

        // Busy beyond four reads: b times out at 0x80, a finishes on 0x00.
        for (int i = 0; i < 5; i++) seq[i] = 8'h80;
        for (int i = 5; i < 8; i++) seq[i] = 8'h00;
        issue(1'b0, 1'b1);
        wait_idle();
        chk("timeout_held", tmo_b, 1);
        for (int i = 0; i < 8; i++) seq[i] = 8'h3C;
        issue(1'b0, 1'b0);
        wait_idle();

        // Request while busy is ignored.
        for (int i = 0; i < 8; i++) seq[i] = 8'hA7;
        issue(1'b1, 1'b0);
        wait_e();
        sel = 1'b0; poll = 1'b1; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        wait_idle();

        // Reset during E high, then a normal read.
        for (int i = 0; i < 8; i++) seq[i] = 8'h9E;
        issue(1'b1, 1'b0);
        wait_e();
        repeat (4) @(negedge clk);
        mid_reset("rst_e_high");
        wait_idle();
        for (int i = 0; i < 8; i++) seq[i] = 8'h5A;
        issue(1'b1, 1'b0);
        wait_idle();

        // Reset during recovery of a poll, after READ_DATA was loaded.
        for (int i = 0; i < 8; i++) seq[i] = 8'hF0;
        seq[7] = 8'h00;
        issue(1'b0, 1'b1);
        wait_e();
        repeat (16) @(negedge clk);
        mid_reset("rst_recover");
        wait_idle();

        // Randomized transactions.
        for (int t = 0; t < 40; t++) begin
            int nb;
            bit pm;
            pm = 1'($urandom_range(0, 1));
            nb = $urandom_range(0, 6);
            for (int i = 0; i < 8; i++) begin
                seq[i] = 8'($urandom);
                if (pm) seq[i][7] = (i < nb);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(1'($urandom_range(0, 1)), pm);
            wait_idle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lcd_bus_reader.md
# lcd_bus_reader

Read-side companion to the character-LCD write sequencer. It performs HD44780-style read cycles (RW=1) on the LCD bus: a single read of the instruction register (busy flag + address counter) or data register, or a busy-flag poll that repeats until the LCD reports ready. It sits beside the write sequencer on the shared LCD pins; external logic grants the pins to one block at a time. This block never drives the data bus.

## Interface
Parameters:
- SETUP_WAIT, 32'd2: cycles RS/RW are stable before E rises (40 ns at 50 MHz).
- ENABLE_WAIT, 32'd12: cycles E is held high (240 ns).
- RECOVERY_WAIT, 32'd14: cycles E is held low after a pulse, before done or the next poll.
- POLL_LIMIT, 32'd100000: maximum reads in poll mode. 0 means no timeout.

Ports (one clock; reset is asynchronous and active-high):
- CLOCK_50MHZ  input  1  system clock.
- BUTTON_SOUTH  input  1  asynchronous active-high reset.
- READ_REQ  input  1  start request; sampled only in IDLE.
- READ_SEL  input  1  register select for a single read: 0 = instruction register, 1 = data register. Captured with the request.
- POLL_MODE  input  1  1 = busy poll (RS forced to 0). Captured with the request.
- READY  output  1  high in IDLE only.
- READ_DONE  output  1  one-cycle pulse marking completion.
- READ_DATA  output  8  last sampled bus value. Holds until the next sample.
- BUSY_TIMEOUT  output  1  valid with READ_DONE. Set when a poll ends on POLL_LIMIT. Held until the next accepted request.
- LCD_DATA_IN  input  8  LCD DB[7:0] as seen by the FPGA.
- LCD_DATA_OE  output  1  bus drive enable. Constant 0.
- LCD_ENABLE  output  1  LCD E.
- LCD_REGISTER_SELECT  output  1  LCD RS.
- LCD_READ_WRITE  output  1  LCD RW.

## Operation
- States: IDLE, SETUP, E_HIGH, RECOVER, DONE.
- IDLE:
  - READY=1, LCD_ENABLE=0, LCD_READ_WRITE=0, RS=0.
  - READ_REQ=1 captures the mode and select, clears BUTTON_SOUTH-independent BUSY_TIMEOUT and the poll count, then moves to SETUP.
- SETUP:
  - Lasts SETUP_WAIT cycles.
  - LCD_READ_WRITE=1.
  - RS = POLL_MODE ? 0 : READ_SEL.
  - Then moves to E_HIGH.
- E_HIGH:
  - LCD_ENABLE=1 for ENABLE_WAIT cycles.
  - READ_DATA is loaded from LCD_DATA_IN on the clock edge that ends the last E_HIGH cycle, at the same edge E falls.
  - Then moves to RECOVER.
- RECOVER:
  - E=0 for RECOVERY_WAIT cycles. RW and RS are unchanged.
  - At the end, the next state is chosen as follows:
    - Single read: DONE.
    - Poll with sampled bit 7 = 0: DONE.
    - Poll with bit 7 = 1 and poll count + 1 == POLL_LIMIT (POLL_LIMIT ≠ 0): DONE, with BUSY_TIMEOUT=1.
    - Otherwise: increment the poll count and return to SETUP.
- DONE:
  - Lasts one cycle. READ_DONE=1, RW=0, RS=0.
  - Returns to IDLE. A request is not accepted in DONE.
- Poll count: a 32-bit count of completed reads. It does not wrap, because it ends at POLL_LIMIT. With POLL_LIMIT=0 it saturates at its maximum value.
- READ_REQ is ignored outside IDLE. A held-high READ_REQ starts a new transaction in the first IDLE cycle.
- Reset (asynchronous, any state, including mid-pulse):
  - State goes to IDLE.
  - LCD_ENABLE=0, LCD_READ_WRITE=0, RS=0, READ_DONE=0, BUSY_TIMEOUT=0, READ_DATA=8'h00, READY=1.
  - Counters go to 0. LCD_DATA_OE is always 0.

## Timing
- Request sampled at edge k. Per read cycle:
  - SETUP occupies cycles k+1..k+S.
  - E is high in cycles k+S+1..k+S+E.
  - RECOVER occupies the following R cycles.
- Single read: READ_DONE is high in cycle k+S+E+R+1. With the defaults this is k+29, and READY returns at k+30.
- Poll with n reads: READ_DONE is high at k+n·(S+E+R)+1.
- Each E pulse is exactly ENABLE_WAIT cycles. E low between pulses is exactly RECOVERY_WAIT+SETUP_WAIT cycles.
- RS and RW change only while E=0. They are stable at least SETUP_WAIT cycles before E rises and RECOVERY_WAIT cycles after E falls.
- All outputs are registered.

## Test plan
- Reset: assert BUTTON_SOUTH mid-stream.
  - Expect E=0, RW=0, RS=0, READY=1, READ_DATA=0x00, READ_DONE=0, BUSY_TIMEOUT=0.
- Single data read: SEL=1, POLL=0, DB=0x41, request at edge k.
  - Expect RS=1 and RW=1 from k+1.
  - Expect E high for exactly 12 cycles (k+3..k+14).
  - Expect READ_DONE only at k+29, READ_DATA=0x41, BUSY_TIMEOUT=0.
- Poll success: DB=0x85 for the first 3 pulses, then 0x05.
  - Expect 4 E pulses, RS=0 throughout.
  - Expect READ_DONE at k+113, READ_DATA=0x05, BUSY_TIMEOUT=0.
- Poll timeout: POLL_LIMIT=4, DB held at 0x80.
  - Expect exactly 4 pulses, then READ_DONE with BUSY_TIMEOUT=1 and READ_DATA=0x80.
  - A following single read clears BUSY_TIMEOUT.
- Request while busy: pulse READ_REQ during E_HIGH.
  - Expect it to be ignored: one READ_DONE only, timing unchanged.
- Reset during E_HIGH:
  - Expect E to fall without waiting for a clock edge, and no READ_DONE.
  - A new request after release completes normally in 29 cycles.
